// File: rtl/l2_playback_player.sv
// ---------------------------------------------------------------------------
// l2_playback_player
// Plays stimulus vectors from a vector memory into an L2 block and compares
// the L2 outputs against the expected half of each memory word.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle pulse, accepted only in IDLE or DONE
//   num_vectors       : vectors to play (ADDR_W+1 bits), sampled on accepted start
//   vec_rd_en/addr    : vector memory read strobe / address
//   vec_rd_data       : memory word, valid one cycle after vec_rd_en
//                       {stimulus[IN_W-1:0], expected[OUT_W-1:0]}
//   stim_out          : registered stimulus to the L2 (MSB is the L2 rst_n)
//   dut_out, cmp_mask : L2 outputs and per-bit compare enable
//   busy, done        : RUN/DRAIN and DONE indications
//   err, mismatch_cnt : sticky error and saturating mismatch count for the run
//   first_err_idx     : index of the first mismatching vector of the run
// ---------------------------------------------------------------------------
module l2_playback_player #(
  parameter int IN_W   = 170,
  parameter int OUT_W  = 71,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_vectors,
  output logic                    vec_rd_en,
  output logic [ADDR_W-1:0]       vec_rd_addr,
  input  logic [IN_W+OUT_W-1:0]   vec_rd_data,
  output logic [IN_W-1:0]         stim_out,
  input  logic [OUT_W-1:0]        dut_out,
  input  logic [OUT_W-1:0]        cmp_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             mismatch_cnt,
  output logic [ADDR_W-1:0]       first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] L_IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] L_IDX_ZERO = {ADDR_W{1'b0}};

  // Masked compare of one L2 output vector against its expected value.
  function automatic logic f_mismatch(input logic [OUT_W-1:0] act,
                                      input logic [OUT_W-1:0] exp,
                                      input logic [OUT_W-1:0] msk);
    f_mismatch = |((act ^ exp) & msk);
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_idx;       // next address to read
  logic [ADDR_W-1:0]   r_last_idx;  // address of the final read of the run
  logic                r_rd_vld;    // a read was issued last cycle
  logic [ADDR_W-1:0]   r_rd_idx;    // index of that read
  logic                r_exp_vld;   // r_exp holds a vector awaiting compare
  logic [OUT_W-1:0]    r_exp;
  logic [ADDR_W-1:0]   r_exp_idx;

  logic w_start_ok;
  logic w_nv_zero;
  logic w_reading;
  logic w_last_rd;
  logic w_mismatch;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_nv_zero   = (num_vectors == {(ADDR_W+1){1'b0}});
  assign w_reading   = (r_state == S_RUN);
  assign w_last_rd   = w_reading && (r_idx == r_last_idx);
  assign w_mismatch  = r_exp_vld && f_mismatch(dut_out, r_exp, cmp_mask);
  assign vec_rd_addr = r_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_next = w_nv_zero ? S_DONE : S_RUN;
        end else begin
          w_next = r_state;
        end
      end
      S_RUN: begin
        if (w_last_rd) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_RUN;
        end
      end
      // The pipeline is empty once the last word sits in r_exp with no read behind it.
      S_DRAIN: begin
        if (r_exp_vld && !r_rd_vld) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    vec_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE:  begin vec_rd_en = 1'b0; busy = 1'b0; done = 1'b0; end
      S_RUN:   begin vec_rd_en = 1'b1; busy = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin vec_rd_en = 1'b0; busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Read pipeline: read -> stimulus/expected register -> compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_idx  <= L_IDX_ZERO;
      r_exp_vld <= 1'b0;
      r_exp     <= {OUT_W{1'b0}};
      r_exp_idx <= L_IDX_ZERO;
      stim_out  <= {IN_W{1'b0}};
    end else begin
      r_rd_vld  <= w_reading;
      r_rd_idx  <= r_idx;
      r_exp_vld <= r_rd_vld;
      // stim_out holds the last stimulus once the run ends.
      if (r_rd_vld) begin
        stim_out  <= vec_rd_data[IN_W+OUT_W-1:OUT_W];
        r_exp     <= vec_rd_data[OUT_W-1:0];
        r_exp_idx <= r_rd_idx;
      end else begin
        stim_out  <= stim_out;
        r_exp     <= r_exp;
        r_exp_idx <= r_exp_idx;
      end
    end
  end

  // Read index, run length and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= L_IDX_ZERO;
      r_last_idx    <= L_IDX_ZERO;
      err           <= 1'b0;
      mismatch_cnt  <= 16'd0;
      first_err_idx <= L_IDX_ZERO;
    end else if (w_start_ok) begin
      r_idx         <= L_IDX_ZERO;
      // For num_vectors = 2^ADDR_W the low bits are zero and this wraps to all-ones.
      r_last_idx    <= num_vectors[ADDR_W-1:0] - L_IDX_ONE;
      err           <= 1'b0;
      mismatch_cnt  <= 16'd0;
      first_err_idx <= L_IDX_ZERO;
    end else begin
      if (w_reading) begin
        r_idx <= r_idx + L_IDX_ONE;
      end else begin
        r_idx <= r_idx;
      end
      if (w_mismatch) begin
        err <= 1'b1;
        if (mismatch_cnt != 16'hFFFF) begin
          mismatch_cnt <= mismatch_cnt + 16'd1;
        end else begin
          mismatch_cnt <= mismatch_cnt;
        end
        if (!err) begin
          first_err_idx <= r_exp_idx;
        end else begin
          first_err_idx <= first_err_idx;
        end
      end else begin
        err           <= err;
        mismatch_cnt  <= mismatch_cnt;
        first_err_idx <= first_err_idx;
      end
    end
  end

endmodule

// File: tb/tb_l2_playback_player.sv
// Directed bench for l2_playback_player with a small configuration
// (IN_W = 8, OUT_W = 8, ADDR_W = 4). Vector i holds stimulus {4'hC, i} and
// expected value stimulus ^ 8'hA5; the modelled L2 returns stim_out ^ 8'hA5,
// with bit 0 flipped for the vectors selected in 'flips'.
module tb_l2_playback_player;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_W:0]       num_vectors;
  logic                  vec_rd_en;
  logic [ADDR_W-1:0]     vec_rd_addr;
  logic [IN_W+OUT_W-1:0] vec_rd_data;
  logic [IN_W-1:0]       stim_out;
  logic [OUT_W-1:0]      dut_out;
  logic [OUT_W-1:0]      cmp_mask;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [15:0]           mismatch_cnt;
  logic [ADDR_W-1:0]     first_err_idx;

  logic [15:0]           flips;
  logic [IN_W+OUT_W-1:0] mem [16];
  int                    errors = 0;
  int                    checks = 0;
  int                    cyc = 0;
  int                    rd_total = 0;
  logic [ADDR_W-1:0]     log_addr [64];
  int                    log_cyc [64];

  l2_playback_player #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .vec_rd_en(vec_rd_en), .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data),
    .stim_out(stim_out), .dut_out(dut_out), .cmp_mask(cmp_mask),
    .busy(busy), .done(done), .err(err), .mismatch_cnt(mismatch_cnt),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  assign dut_out = (stim_out ^ 8'hA5) ^ (flips[stim_out[3:0]] ? 8'h01 : 8'h00);

  // Vector memory with one cycle read latency.
  always @(posedge clk) begin
    if (vec_rd_en) vec_rd_data <= mem[vec_rd_addr];
  end

  // Free-running cycle counter and read log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vec_rd_en) begin
      log_addr[rd_total % 64] <= vec_rd_addr;
      log_cyc[rd_total % 64]  <= cyc;
      rd_total <= rd_total + 1;
    end
  end

  // Start a run of n vectors and wait for done. edges counts clock edges after
  // the accepting edge (0 means done right after acceptance).
  task automatic do_run(input int n, input bit inject, output int edges,
                        output int nreads, output int busy_cnt, output bit addr_ok);
    int s0;
    @(negedge clk);
    start = 1'b1;
    num_vectors = n[ADDR_W:0];
    s0 = rd_total;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    for (int e = 0; e < 40; e++) begin
      if (done) break;
      if (busy) busy_cnt++;
      if (inject) begin
        start = (edges == 2);
        num_vectors = 5'd1;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    nreads = rd_total - s0;
    addr_ok = 1'b1;
    for (int i = 0; i < nreads; i++) begin
      if (log_addr[(s0 + i) % 64] != 4'(i % 16)) addr_ok = 1'b0;
      if (log_cyc[(s0 + i) % 64] != log_cyc[s0 % 64] + i) addr_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    if (stim_out !== 8'h00) begin errors++; $display("FAIL reset_stim: got %0h want 00", stim_out); end
    checks++;
    if (vec_rd_en !== 1'b0 || vec_rd_addr !== 4'h0) begin errors++; $display("FAIL reset_rd: got en=%0b addr=%0h want 0/0", vec_rd_en, vec_rd_addr); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_state: got busy=%0b done=%0b want 0/0", busy, done); end
    checks++;
    if (err !== 1'b0 || mismatch_cnt !== 16'd0 || first_err_idx !== 4'd0) begin errors++; $display("FAIL reset_result: got err=%0b cnt=%0d idx=%0d want 0/0/0", err, mismatch_cnt, first_err_idx); end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    int edges, nreads, bc; bit ok;
    flips = 16'h0000; cmp_mask = 8'hFF;
    do_run(4, 1'b0, edges, nreads, bc, ok);
    if (edges !== 6) begin errors++; $display("FAIL match_latency: got %0d want 6", edges); end
    checks++;
    if (nreads !== 4 || ok !== 1'b1) begin errors++; $display("FAIL match_reads: got n=%0d ok=%0b want 4/1", nreads, ok); end
    checks++;
    if (bc !== 6) begin errors++; $display("FAIL match_busy: got %0d want 6", bc); end
    checks++;
    if (err !== 1'b0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL match_result: got err=%0b cnt=%0d want 0/0", err, mismatch_cnt); end
    checks++;
    if (stim_out !== 8'hC3) begin errors++; $display("FAIL match_stim_hold: got %0h want c3", stim_out); end
    checks++;
  endtask

  task automatic test_mask();
    int edges, nreads, bc; bit ok;
    flips = 16'h000A; cmp_mask = 8'hFE;
    do_run(4, 1'b0, edges, nreads, bc, ok);
    if (err !== 1'b0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL mask_result: got err=%0b cnt=%0d want 0/0", err, mismatch_cnt); end
    checks++;
  endtask

  task automatic test_mismatch();
    int edges, nreads, bc; bit ok;
    flips = 16'h000A; cmp_mask = 8'hFF;
    do_run(4, 1'b0, edges, nreads, bc, ok);
    if (mismatch_cnt !== 16'd2) begin errors++; $display("FAIL mis_cnt: got %0d want 2", mismatch_cnt); end
    checks++;
    if (err !== 1'b1 || first_err_idx !== 4'd1) begin errors++; $display("FAIL mis_first: got err=%0b idx=%0d want 1/1", err, first_err_idx); end
    checks++;
    if (edges !== 6) begin errors++; $display("FAIL mis_latency: got %0d want 6", edges); end
    checks++;
  endtask

  task automatic test_zero();
    int edges, nreads, bc; bit ok;
    do_run(0, 1'b0, edges, nreads, bc, ok);
    if (edges !== 0 || done !== 1'b1) begin errors++; $display("FAIL zero_done: got edges=%0d done=%0b want 0/1", edges, done); end
    checks++;
    if (nreads !== 0 || bc !== 0) begin errors++; $display("FAIL zero_reads: got reads=%0d busy=%0d want 0/0", nreads, bc); end
    checks++;
    if (stim_out !== 8'hC3) begin errors++; $display("FAIL zero_stim: got %0h want c3", stim_out); end
    checks++;
    if (err !== 1'b0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL zero_clear: got err=%0b cnt=%0d want 0/0", err, mismatch_cnt); end
    checks++;
  endtask

  task automatic test_reset_midrun();
    bit found;
    int s0;
    flips = 16'hFFFF; cmp_mask = 8'hFF;
    @(negedge clk);
    start = 1'b1; num_vectors = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 20; e++) begin
      if (vec_rd_en && vec_rd_addr == 4'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (found !== 1'b1) begin errors++; $display("FAIL midrun_reach: got %0b want 1", found); end
    checks++;
    rst_n = 1'b0;
    #1;
    if (stim_out !== 8'h00 || vec_rd_en !== 1'b0 || vec_rd_addr !== 4'h0) begin errors++; $display("FAIL midrun_io: got stim=%0h en=%0b addr=%0h want 0/0/0", stim_out, vec_rd_en, vec_rd_addr); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mismatch_cnt !== 16'd0 || first_err_idx !== 4'd0) begin errors++; $display("FAIL midrun_state: got busy=%0b done=%0b err=%0b cnt=%0d want all 0", busy, done, err, mismatch_cnt); end
    checks++;
    s0 = rd_total;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (rd_total !== s0 || busy !== 1'b0 || mismatch_cnt !== 16'd0) begin errors++; $display("FAIL midrun_quiet: got reads=%0d busy=%0b cnt=%0d want 0/0/0", rd_total - s0, busy, mismatch_cnt); end
    checks++;
  endtask

  task automatic test_back_to_back();
    int edges, nreads, bc; bit ok;
    flips = 16'h0000; cmp_mask = 8'hFF;
    do_run(4, 1'b1, edges, nreads, bc, ok);
    if (edges !== 6 || nreads !== 4 || ok !== 1'b1) begin errors++; $display("FAIL b2b_ignore_start: got edges=%0d reads=%0d ok=%0b want 6/4/1", edges, nreads, ok); end
    checks++;
    if (err !== 1'b0 || mismatch_cnt !== 16'd0 || stim_out !== 8'hC3) begin errors++; $display("FAIL b2b_result: got err=%0b cnt=%0d stim=%0h want 0/0/c3", err, mismatch_cnt, stim_out); end
    checks++;
  endtask

  task automatic test_full();
    int edges, nreads, bc; bit ok;
    flips = 16'hFFFF; cmp_mask = 8'hFF;
    do_run(16, 1'b0, edges, nreads, bc, ok);
    if (nreads !== 16 || ok !== 1'b1) begin errors++; $display("FAIL full_reads: got n=%0d ok=%0b want 16/1", nreads, ok); end
    checks++;
    if (edges !== 18) begin errors++; $display("FAIL full_latency: got %0d want 18", edges); end
    checks++;
    if (mismatch_cnt !== 16'd16 || err !== 1'b1 || first_err_idx !== 4'd0) begin errors++; $display("FAIL full_result: got cnt=%0d err=%0b idx=%0d want 16/1/0", mismatch_cnt, err, first_err_idx); end
    checks++;
    if (stim_out !== 8'hCF) begin errors++; $display("FAIL full_stim_hold: got %0h want cf", stim_out); end
    checks++;
  endtask

  initial begin
    logic [7:0] s;
    for (int i = 0; i < 16; i++) begin
      s = 8'hC0 | 8'(i);
      mem[i] = {s, s ^ 8'hA5};
    end
    rst_n = 1'b0;
    start = 1'b0;
    num_vectors = 5'd0;
    flips = 16'h0000;
    cmp_mask = 8'hFF;
    repeat (2) @(posedge clk);
    test_reset();
    test_match();
    test_mask();
    test_mismatch();
    test_zero();
    test_reset_midrun();
    test_back_to_back();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
